// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// signed/unsigned per operation, valid/ready on both sides, abort while running.
module booth_mult_seq #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH:0]     a_q, a_d;
   logic [WIDTH:0]     q_q, q_d;
   logic [WIDTH:0]     m_q, m_d;
   logic               qb_q, qb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic               out_valid_q, out_valid_d;

   logic [WIDTH:0]     a_sum_s;
   logic [WIDTH:0]     a_sh_s;
   logic [WIDTH:0]     q_sh_s;
   logic               qb_sh_s;

   // Booth recoding of {Q[0], q_buff}: subtract on 10, add on 01, hold otherwise
   always_comb begin
      a_sum_s = a_q;
      case ({q_q[0], qb_q})
         2'b10:   a_sum_s = a_q - m_q;
         2'b01:   a_sum_s = a_q + m_q;
         default: a_sum_s = a_q;
      endcase
   end

   assign a_sh_s  = {a_sum_s[WIDTH], a_sum_s[WIDTH:1]};
   assign q_sh_s  = {a_sum_s[0], q_q[WIDTH:1]};
   assign qb_sh_s = q_q[0];

   // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      q_d         = q_q;
      m_d         = m_q;
      qb_d        = qb_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               // one extension bit makes unsigned and signed operands uniform
               m_d     = {is_signed & multiplicand[WIDTH-1], multiplicand};
               q_d     = {is_signed & multiplier[WIDTH-1], multiplier};
               a_d     = '0;
               qb_d    = 1'b0;
               cnt_d   = CNT_W'(WIDTH + 1);
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               a_d   = a_sh_s;
               q_d   = q_sh_s;
               qb_d  = qb_sh_s;
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  result_d    = {a_sh_s[WIDTH-2:0], q_sh_s};
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         q_q         <= '0;
         m_q         <= '0;
         qb_q        <= 1'b0;
         cnt_q       <= '0;
         result_q    <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         q_q         <= q_d;
         m_q         <= m_d;
         qb_q        <= qb_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign result    = result_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and random bench for booth_mult_seq at WIDTH=8 and WIDTH=16 with a result scoreboard.
module tb_booth_mult_seq;

   logic clk = 1'b0;
   logic reset_n;

   logic        in_valid8, in_ready8, is_signed8, abort8, out_valid8, out_ready8, busy8;
   logic [7:0]  mplier8, mcand8;
   logic [15:0] result8;

   logic        in_valid16, in_ready16, is_signed16, abort16, out_valid16, out_ready16, busy16;
   logic [15:0] mplier16, mcand16;
   logic [31:0] result16;

   int total = 0;
   int bad   = 0;
   logic [31:0] sb_q[$];

   always #5 clk = ~clk;

   booth_mult_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .is_signed(is_signed8), .multiplier(mplier8), .multiplicand(mcand8),
      .abort(abort8), .out_valid(out_valid8), .out_ready(out_ready8),
      .result(result8), .busy(busy8)
   );

   booth_mult_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .is_signed(is_signed16), .multiplier(mplier16), .multiplicand(mcand16),
      .abort(abort16), .out_valid(out_valid16), .out_ready(out_ready16),
      .result(result16), .busy(busy16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pop_exp();
      if (sb_q.size() == 0) return 32'hDEAD_BEEF;
      return sb_q.pop_front();
   endfunction

   function automatic logic [31:0] ref16(input logic sgn, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] ea, eb;
      ea = sgn ? {{16{a[15]}}, a} : {16'h0000, a};
      eb = sgn ? {{16{b[15]}}, b} : {16'h0000, b};
      return ea * eb;
   endfunction

   // Called #1 after an edge with the 8-bit unit idle; returns #1 after the accept edge.
   task automatic start8(input logic sgn, input logic [7:0] mp, input logic [7:0] mc);
      chk("accept_ready8", {31'd0, in_ready8}, 32'd1);
      is_signed8 = sgn;
      mplier8    = mp;
      mcand8     = mc;
      in_valid8  = 1'b1;
      @(posedge clk); #1;
      in_valid8  = 1'b0;
   endtask

   task automatic wait_out8(output int cyc);
      cyc = 0;
      while (!out_valid8 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic take8(input string tag);
      chk(tag, {16'h0000, result8}, pop_exp());
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      chk("take_ovalid8", {31'd0, out_valid8}, 32'd0);
      chk("take_iready8", {31'd0, in_ready8}, 32'd1);
   endtask

   initial begin
      int cyc;
      bit found;
      bit seen;
      logic        sgn;
      logic [15:0] ra, rb;

      reset_n    = 1'b0;
      in_valid8  = 1'b0; is_signed8  = 1'b0; mplier8  = 8'h00;  mcand8  = 8'h00;
      abort8     = 1'b0; out_ready8  = 1'b0;
      in_valid16 = 1'b0; is_signed16 = 1'b0; mplier16 = 16'h0000; mcand16 = 16'h0000;
      abort16    = 1'b0; out_ready16 = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk); #1;

      chk("rst_in_ready", {31'd0, in_ready8}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid8}, 32'd0);
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_result", {16'h0000, result8}, 32'h0000_0000);

      // 1: most-negative squared, with exact latency
      sb_q.push_back(32'h0000_4000);
      start8(1'b1, 8'h80, 8'h80);
      chk("t1_busy", {31'd0, busy8}, 32'd1);
      wait_out8(cyc);
      chk("t1_latency", cyc, 32'd9);
      take8("t1_prod");

      // 2: mode coverage
      sb_q.push_back(32'h0000_FE01);
      start8(1'b0, 8'hFF, 8'hFF);
      wait_out8(cyc);
      chk("t2a_latency", cyc, 32'd9);
      take8("t2a_prod");
      sb_q.push_back(32'h0000_FFF1);
      start8(1'b1, 8'hFD, 8'h05);
      wait_out8(cyc);
      take8("t2b_prod");
      sb_q.push_back(32'h0000_04F1);
      start8(1'b0, 8'hFD, 8'h05);
      wait_out8(cyc);
      take8("t2c_prod");

      // 3: backpressure with competing in_valid
      sb_q.push_back(32'h0000_FD44);
      start8(1'b1, 8'd100, 8'hF9);
      wait_out8(cyc);
      chk("t3_latency", cyc, 32'd9);
      is_signed8 = 1'b0; mplier8 = 8'h11; mcand8 = 8'h22; in_valid8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t3_hold_valid", {31'd0, out_valid8}, 32'd1);
         chk("t3_hold_result", {16'h0000, result8}, 32'h0000_FD44);
         chk("t3_hold_iready", {31'd0, in_ready8}, 32'd0);
      end
      in_valid8 = 1'b0;
      take8("t3_prod");

      // 4: abort in RUN, result retained, then a fresh op
      start8(1'b0, 8'd9, 8'd9);
      repeat (3) @(posedge clk);
      #1 abort8 = 1'b1;
      @(posedge clk); #1;
      abort8 = 1'b0;
      chk("t4_idle", {31'd0, in_ready8}, 32'd1);
      chk("t4_busy", {31'd0, busy8}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid8) seen = 1'b1;
         @(posedge clk); #1;
      end
      chk("t4_no_valid", {31'd0, seen}, 32'd0);
      chk("t4_result_kept", {16'h0000, result8}, 32'h0000_FD44);
      sb_q.push_back(32'h0000_002A);
      start8(1'b0, 8'd7, 8'd6);
      wait_out8(cyc);
      take8("t4_prod");

      // 5: asynchronous reset mid-RUN
      start8(1'b1, 8'd50, 8'd50);
      repeat (3) @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      chk("t5_in_ready", {31'd0, in_ready8}, 32'd1);
      chk("t5_out_valid", {31'd0, out_valid8}, 32'd0);
      chk("t5_busy", {31'd0, busy8}, 32'd0);
      chk("t5_result", {16'h0000, result8}, 32'h0000_0000);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      sb_q.push_back(32'h0000_0006);
      start8(1'b1, 8'd2, 8'd3);
      wait_out8(cyc);
      chk("t5_latency", cyc, 32'd9);
      take8("t5_prod");

      // 6: WIDTH=16 random ops with random output backpressure
      for (int n = 0; n < 2000; n++) begin
         sgn = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         chk("t6_ready", {31'd0, in_ready16}, 32'd1);
         sb_q.push_back(ref16(sgn, ra, rb));
         is_signed16 = sgn; mplier16 = ra; mcand16 = rb; in_valid16 = 1'b1;
         @(posedge clk); #1;
         in_valid16 = 1'b0;
         found = 1'b0;
         for (int c = 0; c < 200 && !found; c++) begin
            @(posedge clk); #1;
            if (out_valid16) begin
               out_ready16 = 1'($urandom_range(0, 1));
               if (out_ready16) begin
                  chk("t6_prod", result16, pop_exp());
                  found = 1'b1;
               end
            end
         end
         chk("t6_complete", {31'd0, found}, 32'd1);
         @(posedge clk); #1;
         out_ready16 = 1'b0;
         if (!found) break;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
